// File: rtl/decode_queue.sv
// Instruction buffer between fetch and execute with an RV32IM/Zicsr decoder on the head entry.
// Circular queue of {inst, pc}; the decoded head is presented over a valid/ready handshake.
module decode_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter bit          ENABLE_M   = 1'b1,
  parameter bit          ENABLE_CSR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rs1_addr,
  output logic [4:0]  out_rs2_addr,
  output logic [4:0]  out_rd_addr,
  output logic [31:0] out_imm,
  output logic [2:0]  out_funct3,
  output logic [3:0]  out_alu_op,
  output logic        out_alu_src_b,
  output logic        out_reg_wen,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic        out_is_jal,
  output logic        out_is_jalr,
  output logic        out_is_branch,
  output logic        out_is_lui,
  output logic        out_is_auipc,
  output logic        out_is_m_ext,
  output logic        out_is_csr,
  output logic        out_is_system,
  output logic [1:0]  out_csr_op_type,
  output logic        out_csr_use_imm,
  output logic [11:0] out_csr_addr,
  output logic        out_illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [3:0] AluAdd    = 4'd0;
  localparam logic [3:0] AluSll    = 4'd1;
  localparam logic [3:0] AluSlt    = 4'd2;
  localparam logic [3:0] AluSltu   = 4'd3;
  localparam logic [3:0] AluXor    = 4'd4;
  localparam logic [3:0] AluSrl    = 4'd5;
  localparam logic [3:0] AluOr     = 4'd6;
  localparam logic [3:0] AluAnd    = 4'd7;
  localparam logic [3:0] AluSub    = 4'd8;
  localparam logic [3:0] AluMul    = 4'd9;
  localparam logic [3:0] AluMulh   = 4'd10;
  localparam logic [3:0] AluMulhsu = 4'd11;
  localparam logic [3:0] AluMulhu  = 4'd12;
  localparam logic [3:0] AluSra    = 4'd13;
  localparam logic [3:0] AluDiv    = 4'd14;
  localparam logic [3:0] AluRem    = 4'd15;

  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  assign in_ready  = (count_q < DepthCnt) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage is deliberately not reset; count gates everything visible.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= in_inst;
      pc_mem[wr_ptr_q]   <= in_pc;
    end
  end

  logic [31:0] inst, pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  assign inst   = inst_mem[rd_ptr_q];
  assign pc     = pc_mem[rd_ptr_q];
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op, is_sys;
  logic is_m, is_csr, is_priv, illegal;
  logic [3:0]  alu_op;
  logic [31:0] imm;

  assign is_lui    = (opcode == OpcLui);
  assign is_auipc  = (opcode == OpcAuipc);
  assign is_jal    = (opcode == OpcJal);
  assign is_jalr   = (opcode == OpcJalr);
  assign is_branch = (opcode == OpcBranch);
  assign is_load   = (opcode == OpcLoad);
  assign is_store  = (opcode == OpcStore);
  assign is_opimm  = (opcode == OpcOpImm);
  assign is_op     = (opcode == OpcOp);
  assign is_sys    = (opcode == OpcSystem);
  assign is_m      = is_op && (funct7 == 7'h01);
  assign is_csr    = is_sys && (funct3 != 3'b000) && (funct3 != 3'b100);
  assign is_priv   = is_sys && (funct3 == 3'b000);

  always_comb begin
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) illegal = 1'b1;
    if (!(is_lui || is_auipc || is_jal || is_jalr || is_branch || is_load || is_store ||
          is_opimm || is_op || is_sys)) illegal = 1'b1;
    if (is_op && !(funct7 == 7'h00 || funct7 == 7'h20 || funct7 == 7'h01)) illegal = 1'b1;
    if (is_op && funct7 == 7'h20 && !(funct3 == 3'b000 || funct3 == 3'b101)) illegal = 1'b1;
    if (is_opimm && funct3 == 3'b001 && funct7 != 7'h00) illegal = 1'b1;
    if (is_opimm && funct3 == 3'b101 && !(funct7 == 7'h00 || funct7 == 7'h20)) illegal = 1'b1;
    if (is_sys && funct3 == 3'b100) illegal = 1'b1;
    if (is_m && !ENABLE_M) illegal = 1'b1;
    if (is_csr && !ENABLE_CSR) illegal = 1'b1;
  end

  always_comb begin
    alu_op = AluAdd;
    if (is_sys) begin
      alu_op = AluAdd;
    end else if (is_m) begin
      case (funct3)
        3'b000:        alu_op = AluMul;
        3'b001:        alu_op = AluMulh;
        3'b010:        alu_op = AluMulhsu;
        3'b011:        alu_op = AluMulhu;
        3'b100, 3'b101: alu_op = AluDiv;
        default:       alu_op = AluRem;
      endcase
    end else if (is_branch) begin
      case (funct3[2:1])
        2'b00:   alu_op = AluSub;
        2'b10:   alu_op = AluSlt;
        2'b11:   alu_op = AluSltu;
        default: alu_op = AluAdd;
      endcase
    end else if (is_op || is_opimm) begin
      case (funct3)
        3'b000:  alu_op = (is_op && funct7[5]) ? AluSub : AluAdd;
        3'b001:  alu_op = AluSll;
        3'b010:  alu_op = AluSlt;
        3'b011:  alu_op = AluSltu;
        3'b100:  alu_op = AluXor;
        3'b101:  alu_op = funct7[5] ? AluSra : AluSrl;
        3'b110:  alu_op = AluOr;
        default: alu_op = AluAnd;
      endcase
    end
  end

  always_comb begin
    imm = {{20{inst[31]}}, inst[31:20]};
    if (is_lui || is_auipc) imm = {inst[31:12], 12'h000};
    else if (is_jal)    imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (is_branch) imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (is_store)  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (is_sys)    imm = {27'd0, inst[19:15]};
  end

  logic vld, ctl;
  assign vld = out_valid;
  assign ctl = out_valid && !illegal;

  // Illegal entries keep pc/funct3/register fields so execute can report the trap.
  always_comb begin
    out_pc          = vld ? pc : 32'd0;
    out_rs1_addr    = (vld && !is_lui && !is_auipc) ? inst[19:15] : 5'd0;
    out_rs2_addr    = vld ? inst[24:20] : 5'd0;
    out_rd_addr     = vld ? inst[11:7] : 5'd0;
    out_imm         = vld ? imm : 32'd0;
    out_funct3      = vld ? funct3 : 3'd0;
    out_csr_addr    = vld ? inst[31:20] : 12'd0;
    out_illegal     = vld && illegal;
    out_alu_op      = ctl ? alu_op : AluAdd;
    out_alu_src_b   = ctl && !(is_op || is_branch || is_csr);
    out_reg_wen     = ctl && (is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm ||
                              is_op || is_csr);
    out_is_load     = ctl && is_load;
    out_is_store    = ctl && is_store;
    out_is_jal      = ctl && is_jal;
    out_is_jalr     = ctl && is_jalr;
    out_is_branch   = ctl && is_branch;
    out_is_lui      = ctl && is_lui;
    out_is_auipc    = ctl && is_auipc;
    out_is_m_ext    = ctl && is_m;
    out_is_csr      = ctl && is_csr;
    out_is_system   = ctl && is_priv;
    out_csr_op_type = (ctl && is_csr) ? (funct3[1:0] - 2'd1) : 2'd0;
    out_csr_use_imm = ctl && is_csr && funct3[2];
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, FIFO order/backpressure, flush and async reset.
// A second instance built with ENABLE_M = 0 shares all inputs.
module tb_decode_queue;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [2:0] out_funct3;
  logic [3:0] out_alu_op;
  logic out_alu_src_b, out_reg_wen, out_is_load, out_is_store, out_is_jal, out_is_jalr;
  logic out_is_branch, out_is_lui, out_is_auipc, out_is_m_ext, out_is_csr, out_is_system;
  logic [1:0] out_csr_op_type;
  logic out_csr_use_imm, out_illegal;
  logic [11:0] out_csr_addr;

  logic m0_in_ready, m0_out_valid;
  logic [31:0] m0_out_pc, m0_out_imm;
  logic [4:0] m0_rs1, m0_rs2, m0_rd;
  logic [2:0] m0_funct3;
  logic [3:0] m0_alu_op;
  logic m0_alu_src_b, m0_reg_wen, m0_is_load, m0_is_store, m0_is_jal, m0_is_jalr;
  logic m0_is_branch, m0_is_lui, m0_is_auipc, m0_is_m_ext, m0_is_csr, m0_is_system;
  logic [1:0] m0_csr_op_type;
  logic m0_csr_use_imm, m0_illegal;
  logic [11:0] m0_csr_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .ENABLE_M(1'b1), .ENABLE_CSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rd_addr(out_rd_addr), .out_imm(out_imm), .out_funct3(out_funct3),
    .out_alu_op(out_alu_op), .out_alu_src_b(out_alu_src_b), .out_reg_wen(out_reg_wen),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_jal(out_is_jal),
    .out_is_jalr(out_is_jalr), .out_is_branch(out_is_branch), .out_is_lui(out_is_lui),
    .out_is_auipc(out_is_auipc), .out_is_m_ext(out_is_m_ext), .out_is_csr(out_is_csr),
    .out_is_system(out_is_system), .out_csr_op_type(out_csr_op_type),
    .out_csr_use_imm(out_csr_use_imm), .out_csr_addr(out_csr_addr), .out_illegal(out_illegal)
  );

  decode_queue #(.DEPTH(4), .ENABLE_M(1'b0), .ENABLE_CSR(1'b1)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(m0_out_valid), .out_ready(out_ready),
    .out_pc(m0_out_pc), .out_rs1_addr(m0_rs1), .out_rs2_addr(m0_rs2),
    .out_rd_addr(m0_rd), .out_imm(m0_out_imm), .out_funct3(m0_funct3),
    .out_alu_op(m0_alu_op), .out_alu_src_b(m0_alu_src_b), .out_reg_wen(m0_reg_wen),
    .out_is_load(m0_is_load), .out_is_store(m0_is_store), .out_is_jal(m0_is_jal),
    .out_is_jalr(m0_is_jalr), .out_is_branch(m0_is_branch), .out_is_lui(m0_is_lui),
    .out_is_auipc(m0_is_auipc), .out_is_m_ext(m0_is_m_ext), .out_is_csr(m0_is_csr),
    .out_is_system(m0_is_system), .out_csr_op_type(m0_csr_op_type),
    .out_csr_use_imm(m0_csr_use_imm), .out_csr_addr(m0_csr_addr), .out_illegal(m0_illegal)
  );

  // Push one instruction; returns #1 after the accepting edge.
  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if ({out_pc, out_imm, out_alu_op, out_reg_wen, out_illegal} !== '0) begin
      errors++; $display("FAIL reset_outputs_zero: got pc=%h imm=%h op=%0d", out_pc, out_imm, out_alu_op); end
  endtask

  task automatic test_addi();
    push(32'h00500093, 32'h100);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b exp 1", out_valid); end
    checks++; if (out_rd_addr !== 5'd1) begin errors++; $display("FAIL addi_rd: got %0d exp 1", out_rd_addr); end
    checks++; if (out_rs1_addr !== 5'd0) begin errors++; $display("FAIL addi_rs1: got %0d exp 0", out_rs1_addr); end
    checks++; if (out_imm !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h exp 5", out_imm); end
    checks++; if (out_alu_op !== 4'd0) begin errors++; $display("FAIL addi_alu_op: got %0d exp 0", out_alu_op); end
    checks++; if (out_alu_src_b !== 1'b1) begin errors++; $display("FAIL addi_src_b: got %b exp 1", out_alu_src_b); end
    checks++; if (out_reg_wen !== 1'b1) begin errors++; $display("FAIL addi_reg_wen: got %b exp 1", out_reg_wen); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal: got %b exp 0", out_illegal); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h exp 100", out_pc); end
    pop_one();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_popped: got %b exp 0", out_valid); end
  endtask

  task automatic test_sub_csr();
    push(32'h402081B3, 32'h104);
    checks++; if (out_alu_op !== 4'd8) begin errors++; $display("FAIL sub_alu_op: got %0d exp 8", out_alu_op); end
    checks++; if (out_alu_src_b !== 1'b0) begin errors++; $display("FAIL sub_src_b: got %b exp 0", out_alu_src_b); end
    checks++; if ({out_rs1_addr, out_rs2_addr, out_rd_addr} !== {5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL sub_regs: got %0d/%0d/%0d exp 1/2/3", out_rs1_addr, out_rs2_addr, out_rd_addr); end
    pop_one();
    push(32'h3001D2F3, 32'h108);
    checks++; if (out_is_csr !== 1'b1) begin errors++; $display("FAIL csr_is_csr: got %b exp 1", out_is_csr); end
    checks++; if (out_csr_op_type !== 2'b00) begin errors++; $display("FAIL csr_op_type: got %b exp 00", out_csr_op_type); end
    checks++; if (out_csr_use_imm !== 1'b1) begin errors++; $display("FAIL csr_use_imm: got %b exp 1", out_csr_use_imm); end
    checks++; if (out_csr_addr !== 12'h300) begin errors++; $display("FAIL csr_addr: got %h exp 300", out_csr_addr); end
    checks++; if (out_imm !== 32'd3) begin errors++; $display("FAIL csr_imm: got %h exp 3", out_imm); end
    checks++; if (out_reg_wen !== 1'b1) begin errors++; $display("FAIL csr_reg_wen: got %b exp 1", out_reg_wen); end
    pop_one();
  endtask

  task automatic test_m_ext_illegal();
    push(32'h027302B3, 32'h10C);
    checks++; if (out_alu_op !== 4'd9) begin errors++; $display("FAIL mul_alu_op: got %0d exp 9", out_alu_op); end
    checks++; if (out_is_m_ext !== 1'b1) begin errors++; $display("FAIL mul_is_m_ext: got %b exp 1", out_is_m_ext); end
    checks++; if (m0_illegal !== 1'b1) begin errors++; $display("FAIL mul_nom_illegal: got %b exp 1", m0_illegal); end
    checks++; if (m0_reg_wen !== 1'b0) begin errors++; $display("FAIL mul_nom_reg_wen: got %b exp 0", m0_reg_wen); end
    checks++; if (m0_is_m_ext !== 1'b0) begin errors++; $display("FAIL mul_nom_is_m_ext: got %b exp 0", m0_is_m_ext); end
    checks++; if (m0_rd !== 5'd5) begin errors++; $display("FAIL mul_nom_rd: got %0d exp 5", m0_rd); end
    pop_one();
    push(32'hFFFFFFFF, 32'h110);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ones_illegal: got %b exp 1", out_illegal); end
    checks++; if (out_reg_wen !== 1'b0 || out_alu_op !== 4'd0) begin
      errors++; $display("FAIL ones_ctrl: got wen=%b op=%0d exp 0/0", out_reg_wen, out_alu_op); end
    checks++; if (out_pc !== 32'h110) begin errors++; $display("FAIL ones_pc: got %h exp 110", out_pc); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h200 + 32'(4 * i);
      @(posedge clk); #1;
    end
    in_inst = 32'h00000013; in_pc = 32'h210;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200) begin
      errors++; $display("FAIL full_hold: got ready=%b pc=%h exp 0/200", in_ready, out_pc); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_pc !== 32'h204) begin errors++; $display("FAIL fifo_pc1: got %h exp 204", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready: got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      exp_pc = 32'h200 + 32'(4 * i);
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        errors++; $display("FAIL fifo_pc%0d: got v=%b pc=%h exp 1/%h", i, out_valid, out_pc, exp_pc); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained: got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push(32'h00000013, 32'h300 + 32'(4 * i));
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00700393; in_pc = 32'h3F0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0", out_valid); end
    push(32'h00100113, 32'h400);
    checks++; if (out_pc !== 32'h400) begin errors++; $display("FAIL flush_next_pc: got %h exp 400", out_pc); end
    pop_one();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_count_zero: got %b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    push(32'h00500093, 32'h500);
    push(32'h402081B3, 32'h504);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b exp 0", out_valid); end
    checks++; if ({out_pc, out_rd_addr, out_imm, out_reg_wen} !== '0) begin
      errors++; $display("FAIL arst_outputs: got pc=%h rd=%0d imm=%h", out_pc, out_rd_addr, out_imm); end
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_release: got v=%b r=%b exp 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub_csr();
    test_m_ext_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction buffer plus RV32IM/Zicsr decoder between fetch and the execute stage. Accepts raw instructions with their PC over a valid/ready handshake and holds up to DEPTH entries. It presents the decoded head entry to execute over a second valid/ready handshake. Adds illegal-instruction detection, build-time M/CSR enables and a pipeline flush, none of which the current combinational decoder provides.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- ENABLE_M, 1: 1 = decode M-extension ops; 0 = flag them illegal
- ENABLE_CSR, 1: 1 = decode CSR ops; 0 = flag them illegal
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous queue clear (branch/trap redirect)
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept
- in_inst  in  32  raw instruction
- in_pc  in  32  its PC
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_pc  out  32  head PC
- out_rs1_addr / out_rs2_addr / out_rd_addr  out  5 each  register fields; rs1 forced 0 for LUI/AUIPC
- out_imm  out  32  immediate: U, J, B, S, zero-extended zimm for SYSTEM, otherwise I
- out_funct3  out  3  inst[14:12]
- out_alu_op  out  4  ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7, SUB 8, MUL 9, MULH 10, MULHSU 11, MULHU 12, SRA 13, DIV 14 (DIV/DIVU), REM 15 (REM/REMU)
- out_alu_src_b  out  1  1 = immediate operand; 0 for OP, BRANCH and CSR
- out_reg_wen, out_is_load, out_is_store, out_is_jal, out_is_jalr, out_is_branch, out_is_lui, out_is_auipc, out_is_m_ext, out_is_csr, out_is_system  out  1 each  control flags
- out_csr_op_type  out  2  00 RW, 01 RS, 10 RC
- out_csr_use_imm  out  1  funct3[2] of a CSR op
- out_csr_addr  out  12  inst[31:20]
- out_illegal  out  1  head instruction is not decodable

## Operation
- Circular buffer of DEPTH {inst, pc} entries with write pointer, read pointer and count.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Pointers wrap modulo DEPTH. Count has width clog2(DEPTH)+1.
- in_ready = (count < DEPTH) && !flush. There is no push-through at full: a pop at full does not enable a push in the same cycle.
- out_valid = (count != 0).
- Decode is combinational from the head entry. Every out_* field other than out_valid is forced to 0 while out_valid = 0.
- ALU op selection, in priority order:
  - CSR and SYSTEM ops select ADD.
  - M ops select by funct3.
  - BRANCH selects SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - OP/OP-IMM select by funct3. funct7[5] selects SUB only for OP, and SRA for both OP and OP-IMM.
- out_illegal is 1 for any of:
  - inst[1:0] != 11
  - opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM}
  - OP with funct7 not in {00, 20, 01}
  - OP with funct7 = 20 and funct3 not in {000, 101}
  - OP-IMM shift with inst[31:25] not 00, or not 20 for SRAI
  - SYSTEM with funct3 = 100
  - an M op when ENABLE_M = 0
  - a CSR op when ENABLE_CSR = 0
- When out_illegal = 1: out_pc, out_funct3 and the register fields are valid; reg_wen and all other control flags are 0; alu_op is ADD. The entry still pops normally so execute can raise the trap.
- Flush has priority over push and pop. It sets count and both pointers to 0 at the edge.

## Timing
- Reset (rst_n low, asynchronous): count and pointers 0, so out_valid = 0 and all decoded outputs = 0. in_ready = 1 once flush is low. Entry storage is not reset.
- Latency: an instruction pushed at edge N is on out_* during the cycle after N. There is no bypass, even when the queue is empty.
- Simultaneous push and pop at 0 < count < DEPTH: count unchanged; head advances and tail advances.
- Simultaneous push and pop at count = DEPTH: pop only (in_ready = 0).
- out_* are stable while out_valid && !out_ready (no change without a pop or flush).
- Fetch must hold in_inst/in_pc while in_valid && !in_ready.
- rst_n asserted mid-stream: queue contents are discarded immediately; out_valid falls without waiting for a clock.

## Test plan
- Reset, push 0x00500093 (addi x1,x0,5) at PC 0x100 -> the next cycle out_valid = 1, rd = 1, rs1 = 0, imm = 5, alu_op = 0, alu_src_b = 1, reg_wen = 1, illegal = 0, pc = 0x100.
- Push 0x402081B3 (sub x3,x1,x2) -> alu_op = 8, alu_src_b = 0, rs1 = 1, rs2 = 2, rd = 3. Push 0x3001D2F3 (csrrwi x5,0x300,3) -> is_csr = 1, csr_op_type = 00, csr_use_imm = 1, csr_addr = 0x300, imm = 3, reg_wen = 1.
- ENABLE_M = 0, push 0x027302B3 (mul x5,x6,x7) -> illegal = 1, reg_wen = 0, is_m_ext = 0. With ENABLE_M = 1 -> alu_op = 9, is_m_ext = 1. Push 0xFFFFFFFF -> illegal = 1.
- DEPTH = 4, out_ready = 0, five back-to-back pushes -> in_ready low after the 4th accept; the 5th is held. Then out_ready = 1 -> pops in FIFO order with the correct PCs, including across pointer wrap.
- Fill 3 entries, assert flush with in_valid = 1 in the same cycle -> next cycle out_valid = 0 and count = 0; the concurrent push is dropped.
- Assert rst_n low mid-stream between clock edges -> out_valid = 0 and decoded outputs = 0 immediately.
